led_bank_arbiter: RTL and testbench

Round-robin arbiter that shares the board's LED bank between four push-button requesters (Input0..Input3).
- Each raw button input is synchronised and debounced.
- The arbiter grants the LED bank to one requester at a time.
- While granted, the LED bank shows that requester's animated pattern for a bounded number of prescaler ticks.
- The block sits directly under the board top, between the button pins and the LED pins.

---
 rtl/led_bank_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the LED bank for four push-button requesters.
// Each button is synchronised and debounced, then granted the bank for a bounded number of pattern ticks.

module led_bank_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the debounced level.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = ~lvl_q;
      else                                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = lvl_q;
endmodule

module led_bank_arbiter #(
  parameter int LED_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 8,
  parameter int HOLD_TICKS      = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Input0,
  input  logic                 Input1,
  input  logic                 Input2,
  input  logic                 Input3,
  output logic [LED_WIDTH-1:0] Led,
  output logic [3:0]           Grant,
  output logic                 Busy
);
  localparam int NUM_REQ = 4;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  logic [NUM_REQ-1:0] raw;
  logic [NUM_REQ-1:0] req;

  assign raw = {Input3, Input2, Input1, Input0};

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_db
      led_bank_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (Clk),
        .rst  (Reset),
        .raw  (raw[i]),
        .level(req[i])
      );
    end
  endgenerate

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [3:0]           grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 pick_vld;
  logic [1:0]           pick;

  function automatic logic [LED_WIDTH-1:0] pat_init(input logic [1:0] owner);
    case (owner)
      2'd0:    pat_init = LED_WIDTH'(1);
      2'd1:    pat_init = LED_WIDTH'(1) << (LED_WIDTH - 1);
      2'd2:    pat_init = '1;
      default: pat_init = LED_WIDTH'(1);
    endcase
  endfunction

  function automatic logic [LED_WIDTH-1:0] pat_next(input logic [1:0] owner,
                                                    input logic [LED_WIDTH-1:0] cur);
    case (owner)
      2'd0:    pat_next = {cur[LED_WIDTH-2:0], cur[LED_WIDTH-1]};
      2'd1:    pat_next = {cur[0], cur[LED_WIDTH-1:1]};
      2'd2:    pat_next = ~cur;
      default: pat_next = cur + LED_WIDTH'(1);
    endcase
  endfunction

  // Free-running; deliberately not re-phased on grant.
  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Search starts just past the previous owner; k==4 wraps back to the previous owner itself.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_q + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    led_d   = led_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        led_d   = '0;
        grant_d = '0;
        hold_d  = '0;
        if (pick_vld) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << pick;
          last_d  = pick;
          led_d   = pat_init(pick);
        end
      end
      S_GRANT: begin
        // Early release wins over tick and hold expiry.
        if (!req[last_q]) begin
          state_d = S_GAP;
          grant_d = '0;
          led_d   = '0;
        end else if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            state_d = S_GAP;
            grant_d = '0;
            led_d   = '0;
          end else begin
            hold_d = hold_q + HW'(1);
            led_d  = pat_next(last_q, led_q);
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        grant_d = '0;
        led_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        led_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      hold_q  <= '0;
      presc_q <= '0;
      led_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      presc_q <= presc_d;
      led_q   <= led_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign Led   = led_q;
  assign Grant = grant_q;
  assign Busy  = busy_q;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: debounce latency, patterns, round-robin order, release, wrap.
`timescale 1ns/1ps
module tb_led_bank_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       in0, in1, in2, in3;
  logic [7:0] led;
  logic [3:0] grant;
  logic       busy;
  logic       b_in3;
  logic [7:0] led_b;
  logic [3:0] grant_b;
  logic       busy_b;

  always #5 clk = ~clk;

  led_bank_arbiter #(.LED_WIDTH(8), .DEBOUNCE_CYCLES(16), .TICK_DIV(8), .HOLD_TICKS(4)) dut (
    .Clk(clk), .Reset(rst), .Input0(in0), .Input1(in1), .Input2(in2), .Input3(in3),
    .Led(led), .Grant(grant), .Busy(busy)
  );

  // Long-hold instance for the counter-wrap check.
  led_bank_arbiter #(.LED_WIDTH(8), .DEBOUNCE_CYCLES(4), .TICK_DIV(2), .HOLD_TICKS(300)) dut_b (
    .Clk(clk), .Reset(rst), .Input0(1'b0), .Input1(1'b0), .Input2(1'b0), .Input3(b_in3),
    .Led(led_b), .Grant(grant_b), .Busy(busy_b)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         idle_seen;
  logic [7:0] seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int bound, output int n);
    n = 0;
    idle_seen = 0;
    while (grant == 4'b0 && n < bound) begin
      step();
      n++;
      if (!busy) idle_seen++;
    end
    chk("grant_arrived", {31'b0, grant != 4'b0}, 32'd1);
  endtask

  task automatic collect(input int bound);
    seq.delete();
    seq.push_back(led);
    for (int i = 0; i < bound; i++) begin
      step();
      if (grant == 4'b0) return;
      if (led != seq[$]) seq.push_back(led);
    end
    chk("collect_timeout", {28'b0, grant}, 32'd0);
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] exp[4]);
    chk({tag, "_len"}, seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk(tag, seq[i], exp[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    int n, bad, ticks;
    logic [7:0] prev;
    logic [3:0] rr_exp[5];
    logic [3:0] alt_exp[4];
    rst = 1'b1; in0 = 0; in1 = 0; in2 = 0; in3 = 0; b_in3 = 0;
    step();

    // Reset state and quiet idle
    do_reset();
    chk("rst_led", led, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    bad = 0;
    repeat (200) begin
      step();
      if (led != 0 || grant != 0 || busy) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Short glitch is filtered out
    in0 = 1; repeat (10) step(); in0 = 0;
    bad = 0;
    repeat (40) begin
      step();
      if (grant != 0) bad++;
    end
    chk("glitch_no_grant", bad, 0);

    // Held press: 2 sync + 16 debounce + 1 grant edges
    in0 = 1;
    wait_grant(100, n);
    chk("db_latency", n, 19);
    chk("grant0", grant, 4'b0001);
    collect(100);
    chk_seq("pat0", '{8'h01, 8'h02, 8'h04, 8'h08});
    chk("gap_grant", grant, 0);
    chk("gap_led", led, 0);
    chk("gap_busy", busy, 1);
    step();
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
    step();
    chk("regrant0", grant, 4'b0001);
    chk("regrant_led", led, 8'h01);

    // Reset mid-grant clears outputs on the next edge
    step(); step();
    rst = 1;
    step();
    chk("midrst_led", led, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    in0 = 0;
    step(); step();
    rst = 0;

    // Two requesters alternate, starting from owner 1 after reset
    rst = 1; in1 = 1; in3 = 1;
    repeat (2) step();
    rst = 0;
    alt_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    for (int g = 0; g < 4; g++) begin
      wait_grant(100, n);
      chk("alt_grant", grant, alt_exp[g]);
      collect(100);
      if (alt_exp[g] == 4'b0010) chk_seq("pat1", '{8'h80, 8'h40, 8'h20, 8'h10});
      else                       chk_seq("pat3", '{8'h01, 8'h02, 8'h03, 8'h04});
    end
    in1 = 0; in3 = 0;
    do_reset();

    // Early release by owner 2
    in2 = 1;
    wait_grant(100, n);
    chk("rel_grant", grant, 4'b0100);
    chk("rel_led0", led, 8'hFF);
    in2 = 0;
    seq.delete();
    seq.push_back(led);
    bad = 0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (grant != 4'b0100) bad++;
      if (led != seq[$]) seq.push_back(led);
    end
    chk("rel_held", bad, 0);
    chk("rel_ticks_ge2", {31'b0, seq.size() >= 2}, 1);
    if (seq.size() >= 2) chk("rel_led1", seq[1], 8'h00);
    step();
    chk("rel_drop_grant", grant, 0);
    chk("rel_drop_led", led, 0);
    do_reset();

    // All four requesting: strict round robin, one IDLE cycle between grants
    in0 = 1; in1 = 1; in2 = 1; in3 = 1;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int g = 0; g < 5; g++) begin
      wait_grant(200, n);
      if (g > 0) begin
        chk("rr_gap_cycles", n, 2);
        chk("rr_idle_busy", idle_seen, 1);
      end
      chk("rr_grant", grant, rr_exp[g]);
      collect(100);
      chk("rr_ticks", seq.size(), 4);
    end
    in0 = 0; in1 = 0; in2 = 0; in3 = 0;
    do_reset();

    // Owner 3 counter wraps 0xFF -> 0x00 at tick 255
    rst = 1; b_in3 = 1;
    step();
    rst = 0;
    n = 0;
    while (grant_b == 4'b0 && n < 100) begin step(); n++; end
    chk("wrap_grant", grant_b, 4'b1000);
    chk("wrap_led0", led_b, 8'h01);
    prev = led_b;
    ticks = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (led_b != prev) begin
        ticks++;
        if (ticks == 254) chk("wrap_pre", led_b, 8'hFF);
        if (ticks == 255) begin
          chk("wrap_post", led_b, 8'h00);
          break;
        end
        prev = led_b;
      end
    end
    chk("wrap_ticks", ticks, 255);
    chk("wrap_still_granted", grant_b, 4'b1000);
    b_in3 = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
